hack_alu_mc: RTL and testbench
==============================

Name: hack_alu_mc

Overview:
Parametrised, handshaked successor to the combinational Hack ALU. It keeps the six Hack control bits (zx, nx, zy, ny, f, no) and adds a multi-cycle multiply mode that uses a shift-add datapath. Results and flags are registered and presented through a valid/ready output. It sits between the Hack CPU decode stage and the D/A/M writeback path, so the CPU can stall on a multiply.

Parameters:
WIDTH, 16, datapath width in bits (legal range 4..64).
MUL_EN, 1, 1 enables multiply mode; 0 forces the mul input to be treated as 0 (multiplier logic removed).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand/control bundle is valid.
in_ready  out  1  block accepts the bundle this cycle.
x  in  WIDTH  operand X.
y  in  WIDTH  operand Y.
zx, nx, zy, ny, f, no  in  1 each  Hack ALU control bits, standard meaning.
mul  in  1  1 = multiply mode (f ignored).
out_valid  out  1  out, zr and ng are valid.
out_ready  in  1  consumer takes the result.
out  out  WIDTH  registered result.
zr  out  1  out == 0.
ng  out  1  out[WIDTH-1].
busy  out  1  high while in the MUL state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out=0, zr=0, ng=0, out_valid=0, busy=0; multiply registers cleared.
  - Reset mid-multiply aborts the operation; no result is produced.
- Accept happens when in_valid && in_ready. All inputs are sampled only on the accept edge; later input changes are ignored.
- Preprocessing:
  - x1 = zx ? 0 : x, then x1 = nx ? ~x1 : x1.
  - y1 is formed the same way from y with zy and ny.
- Normal op (mul=0):
  - r = f ? (x1+y1) : (x1&y1). The sum is modulo 2^WIDTH; carry is discarded.
  - out = no ? ~r : r.
  - out, zr, ng and out_valid are written on the accept edge, so latency is 1 cycle.
  - Next state: DONE.
- Multiply (mul=1, MUL_EN=1):
  - The accept edge loads mcand=x1, mplier=y1, acc=0, cnt=0 and moves to state MUL with busy=1.
  - Each MUL edge:
    - if mplier[0]=1, acc += mcand;
    - then mcand <<= 1, mplier >>= 1, cnt++.
  - On the edge where cnt==WIDTH-1, the step completes and out = no ? ~acc_final : acc_final, with flags from that value.
  - That same edge sets out_valid=1, busy=0 and moves to DONE.
  - Latency is exactly WIDTH cycles from accept to out_valid. The result is the low WIDTH bits of x1*y1.
  - No early termination when mplier becomes 0; latency is fixed.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 throughout MUL.
- DONE state:
  - out_ready=1 without a new accept → IDLE, out_valid=0.
  - out_ready=1 with a simultaneous accept → the result is consumed and the new op is loaded on the same edge (back-to-back, no bubble for normal ops).
  - out_ready=0 → out, zr, ng and out_valid hold, stable.
- out, zr and ng change only on result-producing edges. They keep their last value after consumption, but are meaningful only while out_valid=1.
- in_valid while not ready is ignored; the upstream must hold the bundle.

Decomposition:
- Package hack_alu_pkg holds:
  - state enum {IDLE, MUL, DONE};
  - a packed struct alu_ctrl_t {zx, nx, zy, ny, f, no, mul};
  - localparam for counter width = $clog2(WIDTH).
- Sub-module hack_alu_core (combinational, WIDTH-parametrised) does preprocessing plus the f/no result. It is reused for the normal path; its x1/y1 outputs seed the multiplier.
- The FSM, multiply registers and handshake live in the top level.

Test Plan:
- Reset: hold rst_n=0, then release → out_valid=0, in_ready=1, busy=0, out=0x0000, zr=0, ng=0.
- x+y: x=5, y=3, ctrl 000010, mul=0, out_ready=1 → next cycle out=0x0008, zr=0, ng=0, out_valid=1. Back-to-back with x=3, y=5, ctrl 010011 (x-y) → following cycle out=0xFFFE, ng=1.
- Zero constant: ctrl 101010 with x=0x1234, y=0xBEEF → out=0x0000, zr=1, ng=0.
- Multiply: x=300, y=300, mul=1, ctrl 000000 → busy=1 and in_ready=0 for 16 cycles; out_valid rises exactly 16 cycles after accept with out=0x5F90, zr=0, ng=0. Repeat with no=1 → out=0xA06F, ng=1.
- Backpressure: complete an op with out_ready=0 for 5 cycles while in_valid=1 → out and flags stable, in_ready=0, no new accept; raise out_ready → consumed and the new op accepted on the same edge.
- Reset mid-multiply: pulse rst_n low 8 cycles after a mul accept → out_valid=0, busy=0, in_ready=1 immediately; a subsequent x=7, y=6 multiply yields out=0x002A after 16 cycles.

Source files
------------

// File: rtl/hack_alu_pkg.sv
// Shared types and helpers for the handshaked, multi-cycle Hack ALU.
package hack_alu_pkg;

  // Controller states: idle, shift-add multiply in progress, result held
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Hack control bits plus the multiply-mode select
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
    logic mul;
  } alu_ctrl_t;

  // Step counter width: it only needs to count 0..width-1
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU: operand preprocessing and the f/no result.
module hack_alu_core
  import hack_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  alu_ctrl_t        ctrl,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] x_z;
  logic [WIDTH-1:0] y_z;
  logic [WIDTH-1:0] r;
  logic             unused_mul;

  // The multiply select is handled by the controller, not here
  assign unused_mul = ctrl.mul;

  // Zero then optionally invert each operand; x1/y1 also seed the multiplier
  always_comb begin
    x_z = ctrl.zx ? '0 : x;
    y_z = ctrl.zy ? '0 : y;
    x1  = ctrl.nx ? ~x_z : x_z;
    y1  = ctrl.ny ? ~y_z : y_z;
  end

  // Add (carry dropped) or AND, then optional output inversion
  always_comb begin
    r   = ctrl.f ? (x1 + y1) : (x1 & y1);
    res = ctrl.no ? ~r : r;
  end

endmodule

// File: rtl/hack_alu_mc.sv
// Handshaked Hack ALU with a fixed-latency shift-add multiply mode.
module hack_alu_mc
  import hack_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             no_q, no_d;

  alu_ctrl_t        ctrl;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] core_res;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mul_res;
  logic             mul_eff;
  logic             accept;

  assign ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no, mul: mul};

  // With the multiplier disabled every bundle takes the normal path
  assign mul_eff = MUL_EN && ctrl.mul;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == ST_MUL);

  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign out_valid = out_valid_q;

  hack_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x    (x),
    .y    (y),
    .ctrl (ctrl),
    .x1   (x1),
    .y1   (y1),
    .res  (core_res)
  );

  // One shift-add step and the final (optionally inverted) product
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_res  = no_q ? ~acc_step : acc_step;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      no_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      no_q        <= no_d;
    end
  end

  // Next-state, multiply stepping, result capture and handshake
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    out_valid_d = out_valid_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    no_d        = no_q;

    case (state_q)
      ST_IDLE: begin
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          out_d       = mul_res;
          zr_d        = (mul_res == '0);
          ng_d        = mul_res[WIDTH-1];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new bundle overrides the DONE drain so consume and load share one edge
    if (accept) begin
      if (mul_eff) begin
        mcand_d     = x1;
        mplier_d    = y1;
        acc_d       = '0;
        cnt_d       = '0;
        no_d        = ctrl.no;
        out_valid_d = 1'b0;
        state_d     = ST_MUL;
      end else begin
        out_d       = core_res;
        zr_d        = (core_res == '0);
        ng_d        = core_res[WIDTH-1];
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_hack_alu_mc.sv
// Self-checking bench for hack_alu_mc: arithmetic model plus directed vectors.
`timescale 1ns/1ps
module tb_hack_alu_mc;

  localparam int unsigned W       = 16;
  localparam int          MUL_LAT = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         zx, nx, zy, ny, f, no, mul;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zr;
  logic         ng;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  typedef struct {
    logic [W-1:0] val;
    int           due;
    bit           is_mul;
  } exp_t;

  exp_t exp_q[$];

  hack_alu_mc #(
    .WIDTH  (W),
    .MUL_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .mul       (mul),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Hack ALU semantics from the rules; multiply uses plain integer product
  function automatic logic [W-1:0] model(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                         input logic [5:0] c, input bit m);
    logic [W-1:0]    x1, y1, r;
    longint unsigned p;
    x1 = c[5] ? '0 : xa;
    if (c[4]) x1 = ~x1;
    y1 = c[3] ? '0 : ya;
    if (c[2]) y1 = ~y1;
    if (m) begin
      p = longint'(x1) * longint'(y1);
      r = W'(p);
    end else begin
      r = c[1] ? (x1 + y1) : (x1 & y1);
    end
    if (c[0]) r = ~r;
    return r;
  endfunction

  // Scoreboard: record accepted bundles and drop consumed results
  always @(posedge clk) begin
    exp_t e;
    cyc <= cyc + 1;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        if (exp_q[0].due <= cyc) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        e.val    = model(x, y, {zx, nx, zy, ny, f, no}, mul);
        e.due    = cyc + 1 + (mul ? MUL_LAT : 0);
        e.is_mul = mul;
        exp_q.push_back(e);
      end
    end
  end

  // Cycle-by-cycle compare of handshake, busy and result against the scoreboard
  always @(negedge clk) begin
    bit exp_valid, exp_busy, exp_ready;
    if (rst_n && chk_en) begin
      exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
      exp_busy  = (exp_q.size() > 0) && exp_q[0].is_mul && (cyc < exp_q[0].due);
      exp_ready = exp_busy ? 1'b0 : (exp_valid ? out_ready : 1'b1);
      check("out_valid", out_valid, exp_valid);
      check("busy", busy, exp_busy);
      check("in_ready", in_ready, exp_ready);
      if (exp_valid) begin
        check("out", out, exp_q[0].val);
        check("zr", zr, exp_q[0].val == '0);
        check("ng", ng, exp_q[0].val[W-1]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] xa, input logic [W-1:0] ya,
                       input logic [5:0] c, input bit m);
    x = xa;
    y = ya;
    {zx, nx, zy, ny, f, no} = c;
    mul      = m;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    bit done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        done     = 1;
      end
    end
    if (!done) begin
      timeout_fail(name);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] exp);
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      timeout_fail(name);
    end else begin
      check(name, out, exp);
      check({name, "_zr"}, zr, exp == '0);
      check({name, "_ng"}, ng, exp[W-1]);
    end
  endtask

  typedef struct {
    logic [W-1:0] xa;
    logic [W-1:0] ya;
    logic [5:0]   c;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'd5,    16'd3,    6'b000010, 16'h0008};
    vecs[1] = '{16'h1234, 16'hBEEF, 6'b101010, 16'h0000};
    vecs[2] = '{16'hF0F0, 16'h3C3C, 6'b000000, 16'h3030};
    vecs[3] = '{16'd5,    16'd9,    6'b111111, 16'h0001};
    vecs[4] = '{16'd5,    16'd9,    6'b111010, 16'hFFFF};
    vecs[5] = '{16'h00FF, 16'h1111, 6'b001101, 16'hFF00};

    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0;
    {zx, nx, zy, ny, f, no, mul} = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out", out, 16'h0000);
    check("rst_zr", zr, 0);
    check("rst_ng", ng, 0);
    chk_en = 1;

    // Normal-op vectors, one at a time
    for (int i = 0; i < 6; i++) begin
      step();
      drive(vecs[i].xa, vecs[i].ya, vecs[i].c, 1'b0);
      wait_accept("vec_accept");
      wait_result("vec_out", vecs[i].exp);
    end

    // Back-to-back: x+y then x-y accepted on consecutive edges
    step();
    drive(16'd5, 16'd3, 6'b000010, 1'b0);
    wait_accept("b2b_accept_a");
    fork
      wait_result("b2b_add", 16'h0008);
      begin
        drive(16'd3, 16'd5, 6'b010011, 1'b0);
        wait_accept("b2b_accept_b");
      end
    join
    wait_result("b2b_sub", 16'hFFFE);

    // Multiply, plain and inverted
    step();
    drive(16'd300, 16'd300, 6'b000000, 1'b1);
    wait_accept("mul_accept");
    wait_result("mul_300x300", 16'h5F90);
    step();
    drive(16'd300, 16'd300, 6'b000001, 1'b1);
    wait_accept("muln_accept");
    wait_result("mul_300x300_no", 16'hA06F);

    // Backpressure: result held while a new bundle waits
    step();
    out_ready = 1'b0;
    drive(16'd5, 16'd3, 6'b000010, 1'b0);
    wait_accept("bp_accept_a");
    drive(16'h00FF, 16'h0000, 6'b001101, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out", out, 16'h0008);
      check("bp_out_valid", out_valid, 1);
    end
    step();
    out_ready = 1'b1;
    wait_accept("bp_accept_b");
    wait_result("bp_not_x", 16'hFF00);

    // Reset in the middle of a multiply aborts it
    step();
    drive(16'd300, 16'd300, 6'b000000, 1'b1);
    wait_accept("rstmul_accept");
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rstmul_out_valid", out_valid, 0);
    check("rstmul_busy", busy, 0);
    check("rstmul_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    drive(16'd7, 16'd6, 6'b000000, 1'b1);
    wait_accept("mul7x6_accept");
    wait_result("mul_7x6", 16'h002A);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
